// File: rtl/jt12_bus_pkg.sv
// Shared definitions for the YM2612-style CPU write bus: port codes,
// status bit positions and the busy FSM state encoding.
package jt12_bus_pkg;

   localparam logic [1:0] ADDR0 = 2'b00;
   localparam logic [1:0] DATA0 = 2'b01;
   localparam logic [1:0] ADDR1 = 2'b10;
   localparam logic [1:0] DATA1 = 2'b11;

   localparam int BUSY_BIT  = 7;
   localparam int FLAGB_BIT = 1;
   localparam int FLAGA_BIT = 0;

   typedef enum logic {IDLE, BUSY} busy_state_t;

   // addr[0] separates data ports from address ports; addr[1] is the part
   function automatic logic is_data_port(input logic [1:0] port);
      return port[0];
   endfunction

endpackage

// File: rtl/jt12_busy_cnt.sv
// Busy window generator: a start pulse raises busy for exactly BUSY_CYCLES
// clock cycles, counting the load value down to zero.
module jt12_busy_cnt
   import jt12_bus_pkg::*;
#(
   parameter int BUSY_CYCLES = 32,
   parameter int CNT_W       = 16
)(
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic busy
);

   busy_state_t          state;
   logic [CNT_W-1:0]     cnt;

   // busy falls on the edge where the counter is already zero, so loading
   // BUSY_CYCLES-1 gives BUSY_CYCLES visible busy cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= BUSY;
                  busy  <= 1'b1;
                  cnt   <= CNT_W'(BUSY_CYCLES - 1);
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/jt12_cpu_if.sv
// Chip-side responder for the 4-port CPU write bus: latches the register
// selector, strobes register writes and returns the status byte.
module jt12_cpu_if
   import jt12_bus_pkg::*;
#(
   parameter int BUSY_CYCLES = 32,
   parameter int CNT_W       = 16
)(
   input  logic       rst,
   input  logic       clk,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       flag_a,
   input  logic       flag_b,
   output logic       busy,
   output logic       reg_wr,
   output logic       reg_part,
   output logic [7:0] reg_sel,
   output logic [7:0] reg_val,
   output logic       lost
);

   logic       we;
   logic       we_q;
   logic       acc;
   logic       start;
   logic [7:0] sel;
   logic       part;
   logic [1:0] flags_q;

   assign we    = ~cs_n & ~wr_n;
   assign acc   = we & ~we_q;
   assign start = acc & is_data_port(addr) & ~busy;

   jt12_busy_cnt #(
      .BUSY_CYCLES (BUSY_CYCLES),
      .CNT_W       (CNT_W)
   ) u_busy (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .busy  (busy)
   );

   // The data write's own addr[1] is ignored: the part comes from the last
   // address write, and the latched selector survives repeated data writes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q     <= 1'b0;
         sel      <= 8'h00;
         part     <= 1'b0;
         reg_wr   <= 1'b0;
         reg_part <= 1'b0;
         reg_sel  <= 8'h00;
         reg_val  <= 8'h00;
         lost     <= 1'b0;
         flags_q  <= 2'b00;
      end else begin
         we_q    <= we;
         reg_wr  <= 1'b0;
         flags_q <= {flag_b, flag_a};
         if (acc && !is_data_port(addr)) begin
            sel  <= din;
            part <= addr[1];
         end
         if (acc && is_data_port(addr)) begin
            if (!busy) begin
               reg_wr   <= 1'b1;
               reg_val  <= din;
               reg_sel  <= sel;
               reg_part <= part;
            end else begin
               lost <= 1'b1;
            end
         end
      end
   end

   // Built from registers only, so dout[7] tracks busy on the same cycle
   always_comb begin
      dout            = 8'h00;
      dout[BUSY_BIT]  = busy;
      dout[FLAGB_BIT] = flags_q[1];
      dout[FLAGA_BIT] = flags_q[0];
   end

endmodule

// File: tb/tb_jt12_cpu_if.sv
// Self-checking bench for jt12_cpu_if: directed table, hand sequences for the
// multi-cycle corners, and randomized traffic against a behavioural model.
module tb_jt12_cpu_if;
   import jt12_bus_pkg::*;

   localparam int BUSY_CYCLES = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic       cs_n, wr_n;
   logic [1:0] addr;
   logic [7:0] din;
   logic       flag_a, flag_b;
   logic [7:0] dout;
   logic       busy, reg_wr, reg_part, lost;
   logic [7:0] reg_sel, reg_val;

   int compared   = 0;
   int mismatched = 0;

   jt12_cpu_if #(.BUSY_CYCLES(BUSY_CYCLES), .CNT_W(16)) dut (
      .rst(rst), .clk(clk), .cs_n(cs_n), .wr_n(wr_n), .addr(addr), .din(din),
      .dout(dout), .flag_a(flag_a), .flag_b(flag_b), .busy(busy),
      .reg_wr(reg_wr), .reg_part(reg_part), .reg_sel(reg_sel),
      .reg_val(reg_val), .lost(lost)
   );

   always #5 clk = ~clk;

   // Reference model: remaining visible busy cycles plus the bus latches
   int         m_busy_rem;
   logic       m_we_q, m_part, m_reg_wr, m_reg_part, m_lost;
   logic [7:0] m_sel, m_reg_sel, m_reg_val;
   logic [1:0] m_flags;

   task automatic modelReset();
      m_busy_rem = 0;  m_we_q = 1'b0;  m_part = 1'b0;  m_sel = 8'h00;
      m_reg_wr = 1'b0; m_reg_part = 1'b0; m_reg_sel = 8'h00; m_reg_val = 8'h00;
      m_lost = 1'b0;   m_flags = 2'b00;
   endtask

   task automatic modelEdge(input logic c, input logic w, input logic [1:0] a,
                            input logic [7:0] d, input logic fa, input logic fb);
      logic we, acc, was_busy, started;
      we       = !c && !w;
      acc      = we && !m_we_q;
      was_busy = m_busy_rem > 0;
      started  = 1'b0;
      m_reg_wr = 1'b0;
      if (acc && !a[0]) begin
         m_sel  = d;
         m_part = a[1];
      end
      if (acc && a[0]) begin
         if (!was_busy) begin
            m_reg_wr = 1'b1; m_reg_val = d; m_reg_sel = m_sel; m_reg_part = m_part;
            m_busy_rem = BUSY_CYCLES;
            started = 1'b1;
         end else begin
            m_lost = 1'b1;
         end
      end
      if (!started && m_busy_rem > 0) m_busy_rem--;
      m_flags = {fb, fa};
      m_we_q  = we;
   endtask

   task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name);
      logic [27:0] act, exp;
      logic        mb;
      mb  = m_busy_rem > 0;
      act = {dout, busy, reg_wr, reg_part, reg_sel, reg_val, lost};
      exp = {mb, 5'b00000, m_flags, mb, m_reg_wr, m_reg_part, m_reg_sel, m_reg_val, m_lost};
      expectEq(name, 32'(act), 32'(exp));
   endtask

   // Present inputs, let one edge take them, then check against the model
   task automatic applyStimulus(input logic c, input logic w, input logic [1:0] a,
                                input logic [7:0] d, input string name);
      cs_n = c; wr_n = w; addr = a; din = d;
      @(posedge clk);
      #1;
      modelEdge(c, w, a, d, flag_a, flag_b);
      checkOutput(name);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, ADDR0, 8'h00, "idle");
   endtask

   task automatic waitIdle(input int max_cycles);
      int k;
      k = 0;
      while (busy && k < max_cycles) begin
         applyStimulus(1'b1, 1'b1, ADDR0, 8'h00, "wait_idle");
         k++;
      end
      expectEq("wait_idle_timeout", 32'(busy), 32'(0));
   endtask

   typedef struct {
      logic       cs_n, wr_n;
      logic [1:0] addr;
      logic [7:0] din;
      int         reps;
      logic       exp_wr, exp_part;
      logic [7:0] exp_sel, exp_val;
      logic       exp_busy, exp_lost;
   } vec_t;

   vec_t vecs[12];

   initial begin
      int pulses;
      #200_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pulses;
      logic [27:0] act_t, exp_t;

      vecs[0]  = '{1'b0, 1'b0, ADDR0, 8'h28, 1,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, ADDR0, 8'h00, 1,  1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, DATA0, 8'hF0, 1,  1'b1, 1'b0, 8'h28, 8'hF0, 1'b1, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, ADDR0, 8'h00, 1,  1'b0, 1'b0, 8'h28, 8'hF0, 1'b1, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, ADDR0, 8'h00, 30, 1'b0, 1'b0, 8'h28, 8'hF0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, ADDR0, 8'h00, 1,  1'b0, 1'b0, 8'h28, 8'hF0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, ADDR1, 8'hA4, 1,  1'b0, 1'b0, 8'h28, 8'hF0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, ADDR0, 8'h00, 1,  1'b0, 1'b0, 8'h28, 8'hF0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, DATA1, 8'h22, 1,  1'b1, 1'b1, 8'hA4, 8'h22, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, ADDR0, 8'h00, 32, 1'b0, 1'b1, 8'hA4, 8'h22, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, DATA0, 8'h33, 1,  1'b1, 1'b1, 8'hA4, 8'h33, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 1'b1, ADDR0, 8'h00, 32, 1'b0, 1'b1, 8'hA4, 8'h33, 1'b0, 1'b0};

      rst = 1'b1; cs_n = 1'b1; wr_n = 1'b1; addr = 2'b00; din = 8'h00;
      flag_a = 1'b0; flag_b = 1'b0;
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_state");
      rst = 1'b0;

      for (int v = 0; v < 12; v++) begin
         for (int r = 0; r < vecs[v].reps; r++)
            applyStimulus(vecs[v].cs_n, vecs[v].wr_n, vecs[v].addr, vecs[v].din, "table_model");
         act_t = {dout, busy, reg_wr, reg_part, reg_sel, reg_val, lost};
         exp_t = {vecs[v].exp_busy, 7'b0000000, vecs[v].exp_busy, vecs[v].exp_wr,
                  vecs[v].exp_part, vecs[v].exp_sel, vecs[v].exp_val, vecs[v].exp_lost};
         expectEq($sformatf("table_%0d", v), 32'(act_t), 32'(exp_t));
      end

      // A long hold on the data port must yield a single strobe
      pulses = 0;
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b0, 1'b0, DATA0, 8'h55, "hold");
         if (reg_wr) pulses++;
      end
      expectEq("hold_pulses", 32'(pulses), 32'(1));
      expectEq("hold_lost", 32'(lost), 32'(0));
      expectEq("hold_val", 32'(reg_val), 32'(8'h55));
      applyStimulus(1'b1, 1'b1, ADDR0, 8'h00, "hold_release");
      waitIdle(40);

      // Data write during busy is dropped; address write during busy latches
      applyStimulus(1'b0, 1'b0, DATA0, 8'h66, "lost_first");
      idle(3);
      applyStimulus(1'b0, 1'b0, DATA0, 8'h11, "lost_drop");
      expectEq("lost_no_wr", 32'(reg_wr), 32'(0));
      expectEq("lost_val_kept", 32'(reg_val), 32'(8'h66));
      expectEq("lost_set", 32'(lost), 32'(1));
      idle(1);
      applyStimulus(1'b0, 1'b0, ADDR0, 8'h30, "addr_in_busy");
      idle(1);
      waitIdle(40);
      applyStimulus(1'b0, 1'b0, DATA0, 8'h77, "after_busy");
      expectEq("after_busy_sel", 32'({reg_wr, reg_part, reg_sel, reg_val}), 32'({1'b1, 1'b0, 8'h30, 8'h77}));
      idle(1);
      waitIdle(40);

      // Timer flags pass through with one cycle of latency
      flag_a = 1'b1; flag_b = 1'b0;
      idle(1);
      expectEq("dout_idle_flag", 32'(dout), 32'(8'h01));
      applyStimulus(1'b0, 1'b0, DATA0, 8'h00, "flag_busy_wr");
      expectEq("dout_busy_flag", 32'(dout), 32'(8'h81));
      flag_b = 1'b1;
      idle(1);
      expectEq("dout_both_flags", 32'(dout), 32'(8'h83));
      flag_a = 1'b0; flag_b = 1'b0;
      idle(1);
      waitIdle(40);

      // Reset in the middle of a busy window clears everything at once
      applyStimulus(1'b0, 1'b0, DATA0, 8'h99, "pre_reset_wr");
      idle(9);
      rst = 1'b1;
      #2;
      modelReset();
      expectEq("rst_busy", 32'(busy), 32'(0));
      expectEq("rst_lost", 32'(lost), 32'(0));
      expectEq("rst_dout", 32'(dout), 32'(0));
      expectEq("rst_reg_wr", 32'(reg_wr), 32'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_release");
      applyStimulus(1'b0, 1'b0, DATA0, 8'hD5, "post_reset_wr");
      expectEq("post_reset_sel", 32'({reg_wr, reg_part, reg_sel, reg_val}), 32'({1'b1, 1'b0, 8'h00, 8'hD5}));

      // A write accepted on the very edge busy falls is dropped
      idle(31);
      expectEq("last_busy_cycle", 32'(busy), 32'(1));
      applyStimulus(1'b0, 1'b0, DATA1, 8'hE1, "fall_edge_wr");
      expectEq("fall_edge_drop", 32'({reg_wr, busy, lost}), 32'({1'b0, 1'b0, 1'b1}));
      idle(1);
      applyStimulus(1'b0, 1'b0, DATA0, 8'hE2, "next_edge_wr");
      expectEq("next_edge_take", 32'({reg_wr, reg_val}), 32'({1'b1, 8'hE2}));

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         flag_a = ($urandom % 8) == 0;
         flag_b = ($urandom % 8) == 0;
         if (($urandom % 60) == 0) idle(35);
         applyStimulus(($urandom % 4) == 0, ($urandom % 3) == 0, 2'($urandom),
                       8'($urandom), "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
